// File: rtl/debug_io_router_if.sv
// Configuration bus of debug_io_router: one-cycle write strobe with a registered
// acknowledge/error response.
interface debug_io_router_if;
  logic        CFG_WE_I;
  logic [3:0]  CFG_IDX_I;
  logic [31:0] CFG_DATA_I;
  logic        CFG_ACK_O;
  logic        CFG_ERR_O;

  modport master (
    output CFG_WE_I, CFG_IDX_I, CFG_DATA_I,
    input  CFG_ACK_O, CFG_ERR_O
  );

  modport slave (
    input  CFG_WE_I, CFG_IDX_I, CFG_DATA_I,
    output CFG_ACK_O, CFG_ERR_O
  );
endinterface

// File: rtl/debug_io_router.sv
// Routes selected, synchronized source bits to debug outputs, each channel in
// level, rise-stretch, toggle or fall-stretch mode, configured over a write bus.
module debug_io_router #(
  parameter int C_NUM_SRC   = 4,
  parameter int C_SRC_WIDTH = 8,
  parameter int C_NUM_OUT   = 4
) (
  input  logic                             S_AXI_ACLK,
  input  logic                             S_AXI_ARESETN,
  input  logic [C_NUM_SRC*C_SRC_WIDTH-1:0] SRC_I,
  debug_io_router_if.slave                 cfg,
  output logic [C_NUM_OUT-1:0]             DEBUG_O
);

  localparam int          C_TOTAL     = C_NUM_SRC * C_SRC_WIDTH;
  localparam int          IW          = (C_TOTAL > 1) ? $clog2(C_TOTAL) : 1;
  localparam logic [31:0] C_TOTAL_U   = C_TOTAL;
  localparam logic [31:0] C_NUM_OUT_U = C_NUM_OUT;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'd0,
    MODE_RISE   = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_FALL   = 2'd3
  } mode_e;

  logic [C_TOTAL-1:0] sync1_q, sync2_q, sync3_q;
  logic               ack_q, err_q;
  logic               idx_bad, bit_bad, wr_ok;
  logic               unused_cfg;

  // NOTE: sequential state is assigned with <= only, so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= SRC_I;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      ack_q   <= cfg.CFG_WE_I;
      err_q   <= cfg.CFG_WE_I & (idx_bad | bit_bad);
    end
  end

  assign idx_bad       = ({28'd0, cfg.CFG_IDX_I} >= C_NUM_OUT_U);
  assign bit_bad       = ({16'd0, cfg.CFG_DATA_I[15:0]} >= C_TOTAL_U);
  assign wr_ok         = cfg.CFG_WE_I & ~idx_bad & ~bit_bad;
  assign cfg.CFG_ACK_O = ack_q;
  assign cfg.CFG_ERR_O = err_q;
  assign unused_cfg    = ^cfg.CFG_DATA_I[23:18];

  for (genvar i = 0; i < C_NUM_OUT; i++) begin : g_ch
    logic [IW-1:0] sel_q, sel_d;
    mode_e         mode_q, mode_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          tog_q, tog_d;
    logic          dbg_q, dbg_d;
    logic          wr_hit, cur, prev, rise, fall, trig;

    assign wr_hit = wr_ok && (cfg.CFG_IDX_I == 4'(i));
    assign cur    = sync2_q[sel_q];
    assign prev   = sync3_q[sel_q];
    assign rise   = cur & ~prev;
    assign fall   = ~cur & prev;
    assign trig   = (mode_q == MODE_RISE) ? rise : fall;

    // NOTE: every signal written here gets its default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
      sel_d  = sel_q;
      mode_d = mode_q;
      len_d  = len_q;
      cnt_d  = cnt_q;
      tog_d  = tog_q;
      dbg_d  = dbg_q;
      if (wr_hit) begin
        // A write on this channel discards any edge seen in the same cycle.
        sel_d  = cfg.CFG_DATA_I[IW-1:0];
        mode_d = mode_e'(cfg.CFG_DATA_I[17:16]);
        len_d  = cfg.CFG_DATA_I[31:24];
        cnt_d  = 8'd0;
        tog_d  = 1'b0;
        dbg_d  = 1'b0;
      end else begin
        unique case (mode_q)
          MODE_LEVEL: dbg_d = cur;
          MODE_RISE, MODE_FALL: begin
            if (trig) begin
              cnt_d = len_q;
              dbg_d = 1'b1;
            end else if (cnt_q != 8'd0) begin
              cnt_d = cnt_q - 8'd1;
              dbg_d = 1'b1;
            end else begin
              dbg_d = 1'b0;
            end
          end
          MODE_TOGGLE: begin
            tog_d = tog_q ^ rise;
            dbg_d = tog_q ^ rise;
          end
        endcase
      end
    end

    // NOTE: the configuration registers are reset too, because the reset
    // config is functional (channel i shows bit 0 of source i out of reset).
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
        sel_q  <= IW'((i % C_NUM_SRC) * C_SRC_WIDTH);
        mode_q <= MODE_LEVEL;
        len_q  <= 8'd0;
        cnt_q  <= 8'd0;
        tog_q  <= 1'b0;
        dbg_q  <= 1'b0;
      end else begin
        sel_q  <= sel_d;
        mode_q <= mode_d;
        len_q  <= len_d;
        cnt_q  <= cnt_d;
        tog_q  <= tog_d;
        dbg_q  <= dbg_d;
      end
    end

    assign DEBUG_O[i] = dbg_q;
  end

endmodule

// File: doc/debug_io_router.md
DEBUG_IO_ROUTER -- requirements
Module: debug_io_router

Interface
REQ-001 SHALL have parameter C_NUM_SRC, default 4: number of source buses.
REQ-002 SHALL have parameter C_SRC_WIDTH, default 8: width of each source bus.
REQ-003 SHALL have parameter C_NUM_OUT, default 4: number of debug output channels, 1..16.
REQ-004 SHALL have port S_AXI_ACLK  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port S_AXI_ARESETN  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port SRC_I  input  C_NUM_SRC*C_SRC_WIDTH  flattened sources; source k occupies bits [k*C_SRC_WIDTH +: C_SRC_WIDTH]; asynchronous to the clock.
REQ-007 SHALL have port CFG_WE_I  input  1  config write strobe, one cycle per write.
REQ-008 SHALL have port CFG_IDX_I  input  4  target output channel of the write.
REQ-009 SHALL have port CFG_DATA_I  input  32  [15:0] flat bit index into SRC_I; [17:16] mode; [31:24] stretch length LEN.
REQ-010 SHALL have port CFG_ACK_O  output  1  one-cycle pulse on the edge after each CFG_WE_I.
REQ-011 SHALL have port CFG_ERR_O  output  1  valid with CFG_ACK_O; 1 = write rejected.
REQ-012 SHALL have port DEBUG_O  output  C_NUM_OUT  registered debug outputs.

Function
REQ-013 SHALL pass every SRC_I bit through a 2-FF synchronizer plus one history FF (sync3) for edge detection.
REQ-014 SHALL hold per channel: bit index, mode, LEN, 8-bit stretch counter, toggle state.
REQ-015 Mode 0 (level): DEBUG_O[i] SHALL equal the selected synchronized bit; latency 3 rising edges from SRC_I change to DEBUG_O.
REQ-016 Mode 1 (rise stretch): on a sync2=1/sync3=0 condition, DEBUG_O[i] SHALL assert for exactly LEN+1 cycles; same 3-edge latency as mode 0.
REQ-017 Mode 2 (toggle): DEBUG_O[i] SHALL invert on each detected rising edge of the selected bit.
REQ-018 Mode 3 (fall stretch): same as mode 1 but triggered by sync2=0/sync3=1.
REQ-019 In modes 1/3, an edge detected while stretching SHALL reload the counter; the pulse extends to LEN+1 cycles after the last edge, with no gap.
REQ-020 LEN=0 SHALL give a 1-cycle pulse; LEN=255 SHALL give 256 cycles; the counter SHALL never wrap.
REQ-021 A write SHALL be rejected (config unchanged, CFG_ERR_O=1) when CFG_IDX_I >= C_NUM_OUT or bit index >= C_NUM_SRC*C_SRC_WIDTH.
REQ-022 An accepted write SHALL update the channel on the write edge, clear its counter and toggle state, and drive DEBUG_O[i]=0 on the next edge; the new mode applies from the edge after.
REQ-023 An edge on the same channel coinciding with an accepted write SHALL be discarded; the write wins.
REQ-024 Channels SHALL be independent; a write to channel i SHALL NOT disturb any other channel.
REQ-025 Back-to-back writes on consecutive cycles SHALL each be acknowledged in order, one ACK per write.

Reset
REQ-026 While S_AXI_ARESETN=0: DEBUG_O=0, CFG_ACK_O=0, CFG_ERR_O=0, all sync/history FFs=0, counters=0, toggle states=0, all asynchronously.
REQ-027 Reset config SHALL be: channel i bit index = (i mod C_NUM_SRC)*C_SRC_WIDTH, mode 0, LEN 0, so that DEBUG_O[i] is bit 0 of source i.
REQ-028 Reset asserted mid-stretch or mid-write SHALL abort the operation with no ACK issued; after release the block SHALL restart from the reset config.

Verification
REQ-029 Defaults: after reset release, drive bit 0 of sources 0..3 to 1,0,1,1 -> DEBUG_O=4'b1101 on the 3rd edge; drive source 0 to 0 -> DEBUG_O[0]=0 3 edges later.
REQ-030 Stretch: write ch1 {idx=9, mode=1, LEN=4}; 1-cycle high pulse on SRC_I[9] -> DEBUG_O[1] high exactly 5 cycles; second pulse 2 cycles after the first -> high 7 cycles total, no gap.
REQ-031 Toggle/fall: ch2 mode 2 on SRC_I[16], 3 rising pulses -> DEBUG_O[2] ends at 1; ch3 mode 3 LEN=0 -> a 1-cycle pulse per falling edge of the selected bit.
REQ-032 Errors: write CFG_IDX_I=5 with C_NUM_OUT=4, then bit index 32 -> CFG_ACK_O=1, CFG_ERR_O=1 on each, DEBUG_O unchanged.
REQ-033 Collision/reset: write ch0 on the same edge as a detected edge -> ch0 low next cycle with no pulse; assert reset during a LEN=255 stretch -> DEBUG_O=0 immediately, reset config restored.
